// File: rtl/log2_base_convert.sv
// rtl/log2_base_convert.sv - scales a Q(N).(N) log2 value by constant K via serial shift-add
// One K bit per clock in CALC, then a single round-half-up step in ROUND.
module log2_base_convert #(
  parameter int N = 16,
  parameter logic [N-1:0] K = 16'd19728
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] ynguyen_i,
  input  logic [N-1:0] ythapphan_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] ynguyen_o,
  output logic [N-1:0] ythapphan_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;

  state_t          state_q, state_d;
  logic [3*N-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  x_q, x_d;
  logic [2*N-1:0]  res_q, res_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = {ynguyen_i, ythapphan_i};
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (K[cnt_q])
          acc_d = acc_q + ({{N{1'b0}}, x_q} << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1))
          state_d = ROUND;
      end
      ROUND: begin
        // Adding 2^(N-1) then dropping N bits equals adding bit N-1 to the upper part.
        res_d   = acc_q[3*N-1:N] + {{(2*N-1){1'b0}}, acc_q[N-1]};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ynguyen_o   = res_q[2*N-1:N];
  assign ythapphan_o = res_q[N-1:0];

endmodule

// File: tb/tb_log2_base_convert.sv
// tb/tb_log2_base_convert.sv - scoreboard bench for log2_base_convert (log10 and ln instances)
module tb_log2_base_convert;

  localparam logic [15:0] K10 = 16'd19728;
  localparam logic [15:0] KLN = 16'd45426;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] yi = '0, yf = '0;
  logic        busy, done;
  logic [15:0] oi, of;

  logic        start_ln = 1'b0;
  logic [15:0] yi_ln = '0, yf_ln = '0;
  logic        busy_ln, done_ln;
  logic [15:0] oi_ln, of_ln;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_ln_q[$];

  log2_base_convert #(.N(16), .K(K10)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .ynguyen_i(yi), .ythapphan_i(yf),
    .busy_o(busy), .done_o(done), .ynguyen_o(oi), .ythapphan_o(of)
  );

  log2_base_convert #(.N(16), .K(KLN)) u_ln (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_ln),
    .ynguyen_i(yi_ln), .ythapphan_i(yf_ln),
    .busy_o(busy_ln), .done_o(done_ln), .ynguyen_o(oi_ln), .ythapphan_o(of_ln)
  );

  always #5 clk = ~clk;

  // Reference: round-half-up of X*K / 2^16, done in 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [15:0] k, input logic [15:0] i,
                                        input logic [15:0] f);
    longint unsigned x, p;
    x = 64'({i, f});
    p = x * 64'(k) + 64'd32768;
    return 32'(p >> 16);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result_log10", {oi, of}, exp_q.pop_front());
    end
    if (done_ln === 1'b1) begin
      if (exp_ln_q.size() == 0) check("unexpected_done_ln", 32'd1, 32'd0);
      else check("result_ln", {oi_ln, of_ln}, exp_ln_q.pop_front());
    end
  end

  task automatic convert(input logic [15:0] i, input logic [15:0] f);
    int n, nb;
    @(negedge clk);
    yi = i; yf = f; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(K10, i, f));
    @(negedge clk);
    start = 1'b0;
    yi = 16'($urandom); yf = 16'($urandom);
    n = 0; nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd17);
    check("busy_cycles", 32'(nb), 32'd17);
    check("busy_low_on_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int n, m, dn;
    rst_n = 1'b0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", {oi, of}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(16'd10, 16'd0);
    convert(16'd0, 16'd0);
    convert(16'd0, 16'd1);
    convert(16'd0, 16'd2);
    convert(16'd15, 16'hFFFF);
    convert(16'hFFFF, 16'hFFFF);
    for (int r = 0; r < 20; r++) convert(16'($urandom), 16'($urandom));

    // ln(2) instance
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (r == 0) begin yi_ln = 16'd8; yf_ln = 16'd0; end
      else begin yi_ln = 16'($urandom); yf_ln = 16'($urandom); end
      start_ln = 1'b1;
      @(posedge clk);
      exp_ln_q.push_back(model(KLN, yi_ln, yf_ln));
      @(negedge clk);
      start_ln = 1'b0;
      n = 0;
      while (done_ln !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("latency_ln", 32'(n), 32'd17);
    end

    // start held high, inputs changed mid-CALC, back-to-back acceptance on done cycle
    @(negedge clk);
    yi = 16'd10; yf = 16'd0; start = 1'b1;
    exp_q.push_back(model(K10, 16'd10, 16'd0));
    exp_q.push_back(model(K10, 16'd15, 16'hFFFF));
    @(posedge clk);
    repeat (5) @(negedge clk);
    yi = 16'd15; yf = 16'hFFFF;
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    check("b2b_first_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_on_done", 32'(busy), 32'd1);
    m = 1;
    while (done !== 1'b1 && m < 60) begin @(negedge clk); m++; end
    check("done_spacing", 32'(m), 32'd18);
    @(negedge clk);
    check("no_third_start", 32'(busy), 32'd0);

    // asynchronous reset at CALC cycle 8 aborts without done
    @(negedge clk);
    yi = 16'd10; yf = 16'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", {oi, of}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    convert(16'd10, 16'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("scoreboard_ln_drained", 32'(exp_ln_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule
